// File: rtl/dma_pcie_mdma_byp_in_gen.sv
// dma_pcie_mdma_byp_in_gen: packs user copy requests into 256-bit MDMA bypass-in
// descriptors, stamps each with a wrapping ring consumer index, and buffers them
// in a first-word-fall-through FIFO in front of the DMA bypass port.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cfg_en                        allow new requests (buffered entries drain regardless)
//   cfg_ring_size                 ring entries for cidx wrap, 0 = 65536
//   cidx_clr                      pulse: return the cidx counter to 0
//   req_vld/req_rdy               request handshake
//   req_src_addr/dst_addr/len/qid request fields
//   byp_dsc/byp_cidx              FIFO head descriptor and its consumer index
//   byp_vld/byp_rdy               bypass-in handshake
//   fifo_cnt                      FIFO occupancy
//   dsc_sent_cnt                  descriptors accepted by the DMA
module dma_pcie_mdma_byp_in_gen #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_en,
   input  logic [15:0]              cfg_ring_size,
   input  logic                     cidx_clr,
   input  logic                     req_vld,
   output logic                     req_rdy,
   input  logic [63:0]              req_src_addr,
   input  logic [63:0]              req_dst_addr,
   input  logic [27:0]              req_len,
   input  logic [10:0]              req_qid,
   output logic [255:0]             byp_dsc,
   output logic [15:0]              byp_cidx,
   output logic                     byp_vld,
   input  logic                     byp_rdy,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic [CNT_W-1:0]         dsc_sent_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [166:0]  dsc_mem  [DEPTH];
   logic [15:0]   cidx_mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   cidx_q, cidx_cur, cidx_inc;
   logic          enq, deq;
   assign req_rdy = !rst && cfg_en && (fifo_cnt != CW'(DEPTH));
   assign byp_vld = fifo_cnt != '0;
   assign enq     = req_vld && req_rdy;
   assign deq     = byp_vld && byp_rdy;
   // Clear wins over the stored value; an enqueue in the same cycle takes 0.
   assign cidx_cur = cidx_clr ? '0 : cidx_q;
   // ring_size 0 makes the compare value 0xFFFF, giving the natural 16-bit wrap;
   // a counter already past a shrunk ring keeps counting until 0xFFFF.
   assign cidx_inc = (cidx_cur == cfg_ring_size - 16'd1) ? '0 : cidx_cur + 16'd1;
   // Storage is not reset, so mask the head while empty to keep outputs at 0.
   assign byp_dsc  = byp_vld ? {89'b0, dsc_mem[rd_ptr]} : '0;
   assign byp_cidx = byp_vld ? cidx_mem[rd_ptr] : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_cnt     <= '0;
         cidx_q       <= '0;
         dsc_sent_cnt <= '0;
      end else begin
         wr_ptr       <= enq ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr       <= deq ? rd_ptr + AW'(1) : rd_ptr;
         fifo_cnt     <= fifo_cnt + CW'(enq) - CW'(deq);
         cidx_q       <= enq ? cidx_inc : cidx_cur;
         dsc_sent_cnt <= deq ? dsc_sent_cnt + CNT_W'(1) : dsc_sent_cnt;
      end
   end
   always_ff @(posedge clk) begin
      if (enq) begin
         dsc_mem[wr_ptr]  <= {req_qid, req_len, req_dst_addr, req_src_addr};
         cidx_mem[wr_ptr] <= cidx_cur;
      end
   end
endmodule

// File: doc/dma_pcie_mdma_byp_in_gen.md
Name: dma_pcie_mdma_byp_in_gen

Overview:
- Descriptor generator and buffer driving the master side of the MDMA descriptor bypass-in port (dsc/cidx/vld/rdy).
- Accepts simple copy requests from user logic and packs each into a 256-bit bypass descriptor.
- Stamps each descriptor with a ring consumer index that wraps at a run-time ring size.
- Buffers descriptors in a first-word-fall-through FIFO so DMA backpressure never stalls the request source beyond FIFO capacity.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 32, width of the sent-descriptor statistics counter.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- cfg_en  input  1  enables acceptance of new requests; the FIFO drains regardless.
- cfg_ring_size  input  16  ring entries; 0 means 65536.
- cidx_clr  input  1  synchronous pulse that returns the cidx counter to 0.
- req_vld  input  1  request valid.
- req_rdy  output  1  request ready.
- req_src_addr  input  64  source address.
- req_dst_addr  input  64  destination address.
- req_len  input  28  byte length.
- req_qid  input  11  queue id.
- byp_dsc  output  256  bypass descriptor.
- byp_cidx  output  16  consumer index for byp_dsc.
- byp_vld  output  1  bypass valid.
- byp_rdy  input  1  bypass ready from DMA.
- fifo_cnt  output  log2(DEPTH)+1  current FIFO occupancy.
- dsc_sent_cnt  output  CNT_W  count of descriptors accepted by the DMA.

Behaviour:
- Reset values (async assert, all outputs): req_rdy=0, byp_vld=0, byp_dsc=0, byp_cidx=0, fifo_cnt=0, dsc_sent_cnt=0. Internal cidx counter and FIFO pointers = 0. Reset asserted mid-transfer discards all buffered descriptors.
- Descriptor packing at enqueue: dsc[63:0]=src_addr, [127:64]=dst_addr, [155:128]=len, [166:156]=qid, [255:167]=0.
- req_rdy = cfg_en && (fifo_cnt != DEPTH). Combinational from registered state only; no combinational path from byp_rdy to req_rdy.
- Enqueue occurs when req_vld && req_rdy. The packed descriptor and its cidx are written at the tail.
- cidx assignment:
  - Entry takes the current counter value.
  - Counter advances by 1 and wraps to 0 when the value equals ring_size-1.
  - ring_size=0 uses the natural 16-bit wrap. ring_size=1 always yields cidx 0.
- cidx_clr has priority over counter increment:
  - Clear alone: counter becomes 0.
  - Clear in the same cycle as an enqueue: that descriptor gets cidx 0 and the counter becomes 1 (0 if ring_size=1).
- Output side:
  - byp_vld = (fifo_cnt != 0), registered state.
  - byp_dsc and byp_cidx show the FIFO head.
  - Latency: request accepted in cycle N gives byp_vld=1 in N+1 when the FIFO was empty. No same-cycle bypass.
- Dequeue occurs when byp_vld && byp_rdy. Head advances and dsc_sent_cnt increments, wrapping at 2^CNT_W.
- AXI-style stability: once byp_vld=1, byp_dsc and byp_cidx hold until dequeue.
- Simultaneous enqueue and dequeue: fifo_cnt unchanged. Legal at any occupancy below full. At full no enqueue is possible, so only the dequeue happens.
- cfg_ring_size changes take effect on the next enqueue. If the counter is already ≥ the new ring_size, it still increments and wraps at 65535→0. Software must pair a size change with cidx_clr.
- cfg_en deassert: current-cycle enqueue is blocked (req_rdy falls combinationally); buffered entries still drain.
- Pointers are log2(DEPTH) bits with natural wrap; full/empty are derived from fifo_cnt.

Test Plan:
- Single request with src=0x1000, dst=0x2000, len=64, qid=5, byp_rdy=1 -> byp_vld high one cycle after acceptance; dsc[63:0]=0x1000, [127:64]=0x2000, [155:128]=64, [166:156]=5; cidx=0; dsc_sent_cnt=1.
- ring_size=3, 7 back-to-back requests, byp_rdy=1 -> cidx sequence 0,1,2,0,1,2,0.
- byp_rdy=0, 6 requests with DEPTH=4 -> 4 accepted, req_rdy=0 with fifo_cnt=4; byp_dsc held stable. Release byp_rdy -> 4 descriptors in order, then remaining 2 accepted.
- Continuous req_vld with byp_rdy toggling every cycle -> no loss or duplication; dsc_sent_cnt equals enqueue count; fifo_cnt never exceeds 4.
- cidx_clr pulsed with an enqueue while the counter is 7 (ring_size=0) -> that descriptor cidx=0, next cidx=1. cidx_clr pulsed alone -> next cidx=0.
- rst asserted with 3 entries buffered -> byp_vld=0 and fifo_cnt=0 immediately. After release, the first new descriptor has cidx=0 and dsc_sent_cnt restarts from 0.
